// File: rtl/dac_spi_serializer.sv
// dac_spi_serializer: SPI mode-0 transmitter for the stereo DAC output stage.
// Accepts one DATA_WIDTH-bit command word per handshake, shifts it out MSB-first.
// Ports:
//   i_Clock, i_Reset   system clock, synchronous active-high reset
//   i_Data, i_Send     word to send (sampled at acceptance), level send request
//   o_SPI_CS           chip select, active low
//   o_SPI_Clock        SCLK, idles low, DAC samples on rising edge
//   o_SPI_Data         MOSI, MSB first
//   o_Ready            high when idle and able to accept a word
//   o_LDAC             (only with DAC_LDAC_EN) active-low load pulse during the CS gap
// Optional build macro: DAC_LDAC_EN.
module dac_spi_serializer #(
  parameter int DATA_WIDTH = 24,
  parameter int CLK_DIV    = 4,
  parameter int CS_SETUP   = 2,
  parameter int CS_HOLD    = 2,
  parameter int CS_IDLE    = 2
) (
  input  logic                  i_Clock,
  input  logic                  i_Reset,
  input  logic [DATA_WIDTH-1:0] i_Data,
  input  logic                  i_Send,
  output logic                  o_SPI_CS,
  output logic                  o_SPI_Clock,
  output logic                  o_SPI_Data,
  output logic                  o_Ready
`ifdef DAC_LDAC_EN
  ,
  output logic                  o_LDAC
`endif
);

  localparam int BW = $clog2(DATA_WIDTH) + 1;
  localparam int CW = 16;

  localparam logic [CW-1:0] C_DIV   = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] C_SETUP = CW'(CS_SETUP - 1);
  localparam logic [CW-1:0] C_HOLD  = CW'(CS_HOLD - 1);
  localparam logic [CW-1:0] C_IDLE  = CW'(CS_IDLE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_HIGH,
    S_LOW,
    S_HOLD,
    S_GAP
  } state_t;

  state_t                r_State, w_State;
  logic [CW-1:0]         r_Cnt, w_Cnt;
  logic [BW-1:0]         r_Bits, w_Bits;
  logic [DATA_WIDTH-1:0] r_Shift, w_Shift;
  logic                  r_MOSI, w_MOSI;
  logic                  r_CS;
  logic                  r_SCLK;
  logic                  r_Ready;
  logic                  r_LDAC;
  logic                  w_CS_Low;

  always_comb begin
    w_State = r_State;
    w_Cnt   = r_Cnt + CW'(1);
    w_Bits  = r_Bits;
    w_Shift = r_Shift;
    w_MOSI  = r_MOSI;
    unique case (r_State)
      S_IDLE: begin
        w_Cnt = '0;
        if (r_Ready && i_Send) begin
          w_State = S_SETUP;
          w_Shift = i_Data;
          w_MOSI  = i_Data[DATA_WIDTH-1];
          w_Bits  = BW'(DATA_WIDTH);
        end
      end
      S_SETUP: begin
        if (r_Cnt == C_SETUP) begin
          w_State = S_HIGH;
          w_Cnt   = '0;
        end
      end
      S_HIGH: begin
        if (r_Cnt == C_DIV) begin
          w_Cnt = '0;
          if (r_Bits == BW'(1)) begin
            w_State = S_HOLD;
          end else begin
            // Next bit goes out with the falling SCLK edge.
            w_State = S_LOW;
            w_Bits  = r_Bits - BW'(1);
            w_Shift = r_Shift << 1;
            w_MOSI  = r_Shift[DATA_WIDTH-2];
          end
        end
      end
      S_LOW: begin
        if (r_Cnt == C_DIV) begin
          w_State = S_HIGH;
          w_Cnt   = '0;
        end
      end
      S_HOLD: begin
        if (r_Cnt == C_HOLD) begin
          w_State = S_GAP;
          w_Cnt   = '0;
          w_MOSI  = 1'b0;
        end
      end
      S_GAP: begin
        if (r_Cnt == C_IDLE) begin
          w_State = S_IDLE;
          w_Cnt   = '0;
        end
      end
      default: begin
        w_State = S_IDLE;
        w_Cnt   = '0;
      end
    endcase
  end

  assign w_CS_Low = (w_State == S_SETUP) || (w_State == S_HIGH) ||
                    (w_State == S_LOW)   || (w_State == S_HOLD);

  // Pin outputs are registered from the next state so SCLK/CS never glitch.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_State <= S_IDLE;
      r_Cnt   <= '0;
      r_Bits  <= '0;
      r_Shift <= '0;
      r_MOSI  <= 1'b0;
      r_CS    <= 1'b1;
      r_SCLK  <= 1'b0;
      r_Ready <= 1'b1;
      r_LDAC  <= 1'b1;
    end else begin
      r_State <= w_State;
      r_Cnt   <= w_Cnt;
      r_Bits  <= w_Bits;
      r_Shift <= w_Shift;
      r_MOSI  <= w_MOSI;
      r_CS    <= !w_CS_Low;
      r_SCLK  <= (w_State == S_HIGH);
      r_Ready <= (w_State == S_IDLE);
      r_LDAC  <= (w_State != S_GAP);
    end
  end

  assign o_SPI_CS    = r_CS;
  assign o_SPI_Clock = r_SCLK;
  assign o_SPI_Data  = r_MOSI;
  assign o_Ready     = r_Ready;

`ifdef DAC_LDAC_EN
  assign o_LDAC = r_LDAC;
`else
  logic w_Unused;
  assign w_Unused = r_LDAC;
`endif

endmodule
